// File: rtl/multi_mixer.sv
// Weighted multi-channel audio mixer: one MAC per channel per cycle, weights
// glide one step per sample toward button-set targets, result saturated to WIDTH.
module multi_mixer #(
    parameter int NCH   = 4,
    parameter int WIDTH = 18,
    parameter int WBITS = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   audio_in,
    input  logic                   ready,
    input  logic [2:0]             sel,
    input  logic                   up,
    input  logic                   down,
    input  logic [NCH-1:0]         mute,
    output logic [WIDTH-1:0]       audio_out,
    output logic                   out_valid,
    output logic [NCH*WBITS-1:0]   weights,
    output logic                   busy,
    output logic                   overrun
);

    localparam int AW = WIDTH + WBITS + $clog2(NCH) + 1;
    localparam int IW = $clog2(NCH);

    localparam logic [WBITS-1:0]     WMAX     = '1;
    localparam logic [WBITS-1:0]     WINIT    = {1'b1, {(WBITS-1){1'b0}}};
    localparam logic [IW-1:0]        LAST_IDX = IW'(NCH - 1);
    localparam logic signed [AW-1:0] OUT_MAX  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN  = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                  state;
    logic                    up_q;
    logic                    down_q;
    logic                    up_edge;
    logic                    down_edge;
    logic                    sel_ok;
    logic                    accept;
    logic [WBITS-1:0]        tgt [NCH];
    logic [WBITS-1:0]        act [NCH];
    logic [IW-1:0]           idx;

    logic signed [WIDTH-1:0] sample_p0 [NCH];
    logic [NCH-1:0]          mute_p0;
    logic signed [AW-1:0]    acc_p1;
    logic signed [AW-1:0]    wext;
    logic signed [AW-1:0]    sext;
    logic signed [AW-1:0]    term;
    logic signed [AW-1:0]    acc_sum;

    function automatic logic [WBITS-1:0] w_inc(input logic [WBITS-1:0] w);
        if (w == WMAX)
            return w;
        return w + WBITS'(1);
    endfunction

    function automatic logic [WBITS-1:0] w_dec(input logic [WBITS-1:0] w);
        if (w == '0)
            return w;
        return w - WBITS'(1);
    endfunction

    function automatic logic [WBITS-1:0] step_toward(input logic [WBITS-1:0] a,
                                                     input logic [WBITS-1:0] t);
        if (a < t)
            return a + WBITS'(1);
        if (a > t)
            return a - WBITS'(1);
        return a;
    endfunction

    // Weights are unity at 2^WBITS, so dropping WBITS bits restores sample scale.
    function automatic logic signed [WIDTH-1:0] sat_shift(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> WBITS;
        if (s > OUT_MAX)
            return OUT_MAX[WIDTH-1:0];
        if (s < OUT_MIN)
            return OUT_MIN[WIDTH-1:0];
        return s[WIDTH-1:0];
    endfunction

    assign up_edge   = up & ~up_q;
    assign down_edge = down & ~down_q;
    assign sel_ok    = ({1'b0, sel} < 4'(NCH));
    assign accept    = (state == IDLE) && ready;

    for (genvar g = 0; g < NCH; g++) begin : g_weights
        assign weights[g*WBITS +: WBITS] = tgt[g];
    end

    // Stage p0 -> p1: one channel product per ACC cycle, muted channels add zero.
    always_comb begin
        wext    = {{(AW-WBITS){1'b0}}, act[idx]};
        sext    = {{(AW-WIDTH){sample_p0[idx][WIDTH-1]}}, sample_p0[idx]};
        term    = '0;
        if (!mute_p0[idx])
            term = wext * sext;
        acc_sum = acc_p1 + term;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            audio_out <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            idx       <= '0;
            for (int i = 0; i < NCH; i++) begin
                tgt[i] <= WINIT;
                act[i] <= WINIT;
            end
        end else begin
            up_q      <= up;
            down_q    <= down;
            out_valid <= 1'b0;

            // Simultaneous up and down edges cancel out.
            if (sel_ok && (up_edge != down_edge)) begin
                for (int i = 0; i < NCH; i++) begin
                    if (sel == 3'(i))
                        tgt[i] <= up_edge ? w_inc(tgt[i]) : w_dec(tgt[i]);
                end
            end

            if (ready && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (ready) begin
                        state <= ACC;
                        busy  <= 1'b1;
                        idx   <= '0;
                        for (int i = 0; i < NCH; i++)
                            act[i] <= step_toward(act[i], tgt[i]);
                    end
                end
                ACC: begin
                    idx <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        audio_out <= sat_shift(acc_sum);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0 capture and p1 accumulation; data path carries no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < NCH; i++)
                sample_p0[i] <= $signed(audio_in[i*WIDTH +: WIDTH]);
            mute_p0 <= mute;
            acc_p1  <= '0;
        end else if (state == ACC) begin
            acc_p1 <= acc_sum;
        end
    end

endmodule

// File: tb/tb_multi_mixer.sv
// Self-checking bench for multi_mixer (NCH=2, WIDTH=18, WBITS=5) with a
// behavioural model of target/active weights and the mixed output.
module tb_multi_mixer;

    localparam int NCH   = 2;
    localparam int WIDTH = 18;
    localparam int WBITS = 5;
    localparam int AINW  = NCH * WIDTH;
    localparam int WMAXI = (1 << WBITS) - 1;
    localparam longint OMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (WIDTH - 1));

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [AINW-1:0]      audio_in = '0;
    logic                 ready = 1'b0;
    logic [2:0]           sel = '0;
    logic                 up = 1'b0;
    logic                 down = 1'b0;
    logic [NCH-1:0]       mute = '0;
    logic [WIDTH-1:0]     audio_out;
    logic                 out_valid;
    logic [NCH*WBITS-1:0] weights;
    logic                 busy;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;
    int tgt_m [NCH];
    int act_m [NCH];
    bit prev_u = 1'b0;
    bit prev_d = 1'b0;

    multi_mixer #(.NCH(NCH), .WIDTH(WIDTH), .WBITS(WBITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .audio_in  (audio_in),
        .ready     (ready),
        .sel       (sel),
        .up        (up),
        .down      (down),
        .mute      (mute),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .weights   (weights),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NCH*WBITS-1:0] exp_weights();
        logic [NCH*WBITS-1:0] w;
        for (int i = 0; i < NCH; i++)
            w[i*WBITS +: WBITS] = WBITS'(tgt_m[i]);
        return w;
    endfunction

    function automatic logic [AINW-1:0] pack2(input int s0, input int s1);
        logic [AINW-1:0] a;
        a[0 +: WIDTH]     = WIDTH'(s0);
        a[WIDTH +: WIDTH] = WIDTH'(s1);
        return a;
    endfunction

    // Mixed output: sum of weight*sample over unmuted channels, divided by 2^WBITS
    // with floor rounding, then clamped to the signed WIDTH range.
    function automatic logic [WIDTH-1:0] model_mix(input logic [AINW-1:0] ain,
                                                   input logic [NCH-1:0] m);
        longint sum;
        logic signed [WIDTH-1:0] s;
        sum = 0;
        for (int i = 0; i < NCH; i++) begin
            s = $signed(ain[i*WIDTH +: WIDTH]);
            if (!m[i])
                sum += longint'(act_m[i]) * longint'(s);
        end
        sum = sum >>> WBITS;
        if (sum > OMAX) sum = OMAX;
        if (sum < OMIN) sum = OMIN;
        return WIDTH'(sum);
    endfunction

    task automatic model_reset;
        for (int i = 0; i < NCH; i++) begin
            tgt_m[i] = 1 << (WBITS - 1);
            act_m[i] = 1 << (WBITS - 1);
        end
        prev_u = 1'b0;
        prev_d = 1'b0;
    endtask

    // Drive button levels for the coming edge and apply the edge rules to the model.
    task automatic set_buttons(input logic [2:0] s, input logic u, input logic d);
        bit eu;
        bit ed;
        int ch;
        eu = u && !prev_u;
        ed = d && !prev_d;
        ch = int'(s);
        if (ch < NCH && eu != ed) begin
            if (eu)
                tgt_m[ch] = (tgt_m[ch] == WMAXI) ? WMAXI : tgt_m[ch] + 1;
            else
                tgt_m[ch] = (tgt_m[ch] == 0) ? 0 : tgt_m[ch] - 1;
        end
        prev_u = u;
        prev_d = d;
        sel  = s;
        up   = u;
        down = d;
    endtask

    task automatic press(input logic [2:0] s, input logic u, input logic d);
        set_buttons(s, u, d);
        tick;
        set_buttons(s, 1'b0, 1'b0);
        tick;
    endtask

    task automatic do_reset;
        ready    = 1'b0;
        audio_in = '0;
        mute     = '0;
        sel      = '0;
        up       = 1'b0;
        down     = 1'b0;
        reset    = 1'b0;
        model_reset();
        tick;
        tick;
        @(negedge clock);
        reset = 1'b1;
        tick;
    endtask

    // One accepted sample set: checks latency, value, pulse width and weights.
    task automatic run_sample(input logic [AINW-1:0] ain, input logic [NCH-1:0] m,
                              input bit rnd_btn, input string tag);
        logic [WIDTH-1:0] exp_out;
        int lat;
        bit seen;
        audio_in = ain;
        mute     = m;
        ready    = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (act_m[i] < tgt_m[i]) act_m[i]++;
            else if (act_m[i] > tgt_m[i]) act_m[i]--;
        end
        exp_out = model_mix(ain, m);
        tick;
        ready    = 1'b0;
        audio_in = AINW'({$urandom(), $urandom()});
        mute     = NCH'($urandom());
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                if (rnd_btn)
                    set_buttons(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)));
                tick;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: out_valid never rose, required within %0d cycles", tag, NCH + 1);
        end else begin
            checks++;
            if (lat !== NCH + 1) begin
                failures++;
                $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, NCH + 1);
            end
            checks++;
            if (audio_out !== exp_out) begin
                failures++;
                $display("FAIL %s_audio_out: got %0d, required %0d", tag,
                         $signed(audio_out), $signed(exp_out));
            end
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: out_valid=%b busy=%b, required 0 0", tag, out_valid, busy);
        end
        checks++;
        if (weights !== exp_weights()) begin
            failures++;
            $display("FAIL %s_weights: got %h, required %h", tag, weights, exp_weights());
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (audio_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: audio_out=%0d out_valid=%b busy=%b overrun=%b, required 0 0 0 0",
                     audio_out, out_valid, busy, overrun);
        end
        checks++;
        if (weights !== {5'd16, 5'd16}) begin
            failures++;
            $display("FAIL reset_weights: got %h, required %h", weights, {5'd16, 5'd16});
        end
    endtask

    task automatic test_basic;
        run_sample(pack2(1000, 1000), 2'b00, 1'b0, "basic");
        checks++;
        if (audio_out !== 18'd1000) begin
            failures++;
            $display("FAIL basic_const: got %0d, required 1000", $signed(audio_out));
        end
    endtask

    task automatic test_mute;
        run_sample(pack2(3200, 9999), 2'b10, 1'b0, "mute");
        checks++;
        if (audio_out !== 18'd1600) begin
            failures++;
            $display("FAIL mute_const: got %0d, required 1600", $signed(audio_out));
        end
    endtask

    task automatic test_back_to_back;
        int busy_cnt;
        int ov_cnt;
        logic [WIDTH-1:0] exp_out;
        busy_cnt = 0;
        ov_cnt   = 0;
        audio_in = pack2(-5000, 777);
        mute     = 2'b00;
        ready    = 1'b1;
        exp_out  = model_mix(pack2(-5000, 777), 2'b00);
        tick;
        if (busy === 1'b1) busy_cnt++;
        audio_in = pack2(12345, 12345);
        tick;
        if (busy === 1'b1) busy_cnt++;
        if (out_valid === 1'b1) ov_cnt++;
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (busy === 1'b1) busy_cnt++;
            if (out_valid === 1'b1) begin
                ov_cnt++;
                checks++;
                if (audio_out !== exp_out) begin
                    failures++;
                    $display("FAIL b2b_audio_out: got %0d, required %0d",
                             $signed(audio_out), $signed(exp_out));
                end
            end
        end
        checks++;
        if (ov_cnt !== 1) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d out_valid pulses, required 1", ov_cnt);
        end
        checks++;
        if (busy_cnt !== NCH + 1) begin
            failures++;
            $display("FAIL b2b_busy: busy high %0d cycles, required %0d", busy_cnt, NCH + 1);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overrun: got %b, required 1", overrun);
        end
        run_sample(pack2(42, -42), 2'b00, 1'b0, "post_b2b");
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b, required 1", overrun);
        end
    endtask

    task automatic test_abort;
        int pulses;
        pulses   = 0;
        audio_in = pack2(20000, 20000);
        mute     = 2'b00;
        ready    = 1'b1;
        tick;
        ready = 1'b0;
        reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || audio_out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: busy=%b audio_out=%0d out_valid=%b overrun=%b, required 0 0 0 0",
                     busy, audio_out, out_valid, overrun);
        end
        tick;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_pulse: pulses=%0d busy=%b, required 0 0", pulses, busy);
        end
        checks++;
        if (weights !== {5'd16, 5'd16}) begin
            failures++;
            $display("FAIL abort_weights: got %h, required %h", weights, {5'd16, 5'd16});
        end
    endtask

    task automatic test_buttons;
        set_buttons(3'd0, 1'b1, 1'b0);
        tick;
        tick;
        tick;
        set_buttons(3'd0, 1'b0, 1'b0);
        tick;
        checks++;
        if (weights !== {5'd16, 5'd17}) begin
            failures++;
            $display("FAIL btn_hold: got %h, required %h", weights, {5'd16, 5'd17});
        end
        press(3'd0, 1'b1, 1'b1);
        checks++;
        if (weights !== {5'd16, 5'd17}) begin
            failures++;
            $display("FAIL btn_both: got %h, required %h", weights, {5'd16, 5'd17});
        end
        press(3'd5, 1'b1, 1'b0);
        checks++;
        if (weights !== {5'd16, 5'd17}) begin
            failures++;
            $display("FAIL btn_bad_sel: got %h, required %h", weights, {5'd16, 5'd17});
        end
        for (int k = 0; k < 20; k++)
            press(3'd0, 1'b1, 1'b0);
        checks++;
        if (weights !== {5'd16, 5'd31} || weights !== exp_weights()) begin
            failures++;
            $display("FAIL btn_sat_up: got %h, required %h", weights, {5'd16, 5'd31});
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 15; k++)
            press(3'd1, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++)
            run_sample(pack2($urandom_range(0, 100), $urandom_range(0, 100)), 2'b00, 1'b0, "ramp");
        checks++;
        if (act_m[0] !== 31 || act_m[1] !== 31 || weights !== {5'd31, 5'd31}) begin
            failures++;
            $display("FAIL ramp_state: weights=%h, required %h", weights, {5'd31, 5'd31});
        end
        run_sample(pack2(131071, 131071), 2'b00, 1'b0, "sat_pos");
        checks++;
        if (audio_out !== 18'h1FFFF) begin
            failures++;
            $display("FAIL sat_pos_const: got %0d, required 131071", $signed(audio_out));
        end
        run_sample(pack2(-131072, -131072), 2'b00, 1'b0, "sat_neg");
        checks++;
        if (audio_out !== 18'h20000) begin
            failures++;
            $display("FAIL sat_neg_const: got %0d, required -131072", $signed(audio_out));
        end
        for (int k = 0; k < 40; k++)
            press(3'd0, 1'b0, 1'b1);
        checks++;
        if (weights !== {5'd31, 5'd0}) begin
            failures++;
            $display("FAIL btn_sat_down: got %h, required %h", weights, {5'd31, 5'd0});
        end
    endtask

    task automatic test_random;
        int extremes [4] = '{131071, -131072, 0, -1};
        int s0;
        int s1;
        for (int n = 0; n < 40; n++) begin
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                set_buttons(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                tick;
            end
            if ($urandom_range(0, 3) == 0) begin
                s0 = extremes[$urandom_range(0, 3)];
                s1 = extremes[$urandom_range(0, 3)];
            end else begin
                s0 = int'($urandom_range(0, 262143)) - 131072;
                s1 = int'($urandom_range(0, 262143)) - 131072;
            end
            run_sample(pack2(s0, s1), NCH'($urandom()), 1'b1, "rand");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mute();
        test_back_to_back();
        test_abort();
        test_buttons();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
